// File: rtl/alarma_multicanal.sv
// Multi-channel alarm blinker: each channel rings on a rising edge of its
// chronometer-finished flag, blinking until acknowledged or N_BLINKS pairs elapse.
module alarma_multicanal #(
    parameter int N_CH        = 4,
    parameter int HALF_PERIOD = 25,
    parameter int N_BLINKS    = 8
) (
    input  logic            CLK_Ring,
    input  logic            reset,
    input  logic            enable,
    input  logic [N_CH-1:0] fin_crono,
    input  logic [N_CH-1:0] ack,
    output logic [N_CH-1:0] band_parp,
    output logic [N_CH-1:0] alarm_active,
    output logic            any_alarm
);

    localparam int TW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int BW = (N_BLINKS > 0) ? $clog2(N_BLINKS + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(HALF_PERIOD - 1);
    localparam logic [BW-1:0] B_LAST = BW'((N_BLINKS > 0) ? N_BLINKS - 1 : 0);
    localparam logic [BW-1:0] B_SAT  = '1;

    typedef enum logic {IDLE, RING} state_t;

    state_t          state_q  [N_CH];
    state_t          state_d  [N_CH];
    logic [TW-1:0]   timer_q  [N_CH];
    logic [TW-1:0]   timer_d  [N_CH];
    logic [BW-1:0]   blinks_q [N_CH];
    logic [BW-1:0]   blinks_d [N_CH];
    logic [N_CH-1:0] band_q, band_d;
    logic [N_CH-1:0] prev_q, prev_d;
    logic [N_CH-1:0] trig;

    always_comb begin
        prev_d = fin_crono;
        trig   = fin_crono & ~prev_q;
        band_d = band_q;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i]  = state_q[i];
            timer_d[i]  = timer_q[i];
            blinks_d[i] = blinks_q[i];
            // Priority: disable, then a new event, then ack, then the blink timer.
            if (!enable) begin
                state_d[i]  = IDLE;
                band_d[i]   = 1'b0;
                timer_d[i]  = '0;
                blinks_d[i] = '0;
            end else if (trig[i]) begin
                state_d[i]  = RING;
                band_d[i]   = 1'b1;
                timer_d[i]  = '0;
                blinks_d[i] = '0;
            end else if (state_q[i] == RING) begin
                if (ack[i]) begin
                    state_d[i]  = IDLE;
                    band_d[i]   = 1'b0;
                    timer_d[i]  = '0;
                    blinks_d[i] = '0;
                end else if (timer_q[i] == T_LAST) begin
                    timer_d[i] = '0;
                    band_d[i]  = ~band_q[i];
                    // An off phase just ended: one more on/off pair is complete.
                    if (!band_q[i]) begin
                        if ((N_BLINKS != 0) && (blinks_q[i] == B_LAST)) begin
                            state_d[i]  = IDLE;
                            band_d[i]   = 1'b0;
                            blinks_d[i] = '0;
                        end else if (blinks_q[i] != B_SAT) begin
                            blinks_d[i] = blinks_q[i] + 1'b1;
                        end
                    end
                end else begin
                    timer_d[i] = timer_q[i] + 1'b1;
                end
            end
        end
    end

    // History resets high so a level held through reset is not an edge.
    always_ff @(posedge CLK_Ring) begin
        if (!reset) begin
            band_q <= '0;
            prev_q <= '1;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= IDLE;
                timer_q[i]  <= '0;
                blinks_q[i] <= '0;
            end
        end else begin
            band_q <= band_d;
            prev_q <= prev_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= state_d[i];
                timer_q[i]  <= timer_d[i];
                blinks_q[i] <= blinks_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            alarm_active[i] = (state_q[i] == RING);
        end
        any_alarm = |alarm_active;
    end

    assign band_parp = band_q;

endmodule

// File: tb/tb_alarma_multicanal.sv
// Directed bench for alarma_multicanal: a 3-pair instance and a ring-forever
// instance (N_BLINKS=0) share the same stimulus.
module tb_alarma_multicanal;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [1:0] fin_crono;
    logic [1:0] ack;
    logic [1:0] band_parp, alarm_active;
    logic       any_alarm;
    logic [1:0] band_parp_nb0, alarm_active_nb0;
    logic       any_alarm_nb0;

    int n_checks = 0;
    int n_fail   = 0;

    alarma_multicanal #(.N_CH(2), .HALF_PERIOD(4), .N_BLINKS(3)) dut (
        .CLK_Ring(clk), .reset(reset), .enable(enable), .fin_crono(fin_crono),
        .ack(ack), .band_parp(band_parp), .alarm_active(alarm_active),
        .any_alarm(any_alarm)
    );

    alarma_multicanal #(.N_CH(2), .HALF_PERIOD(4), .N_BLINKS(0)) dut_nb0 (
        .CLK_Ring(clk), .reset(reset), .enable(enable), .fin_crono(fin_crono),
        .ack(ack), .band_parp(band_parp_nb0), .alarm_active(alarm_active_nb0),
        .any_alarm(any_alarm_nb0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected blink flag k edges after the triggering edge (4 on, 4 off).
    function automatic logic exp_band(input int k);
        return ((k / 4) % 2) == 0;
    endfunction

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; fin_crono = 2'b11; ack = 2'b00;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (band_parp !== 2'b00 || alarm_active !== 2'b00 || any_alarm !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d band=%b act=%b any=%b required 00/00/0",
                         c, band_parp, alarm_active, any_alarm);
            end
        end
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            n_checks++;
            if (band_parp !== 2'b00 || alarm_active !== 2'b00 ||
                band_parp_nb0 !== 2'b00 || alarm_active_nb0 !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_level_no_trig cyc=%0d band=%b act=%b nb0_band=%b required 00",
                         c, band_parp, alarm_active, band_parp_nb0);
            end
        end
    endtask

    task automatic test_auto_stop();
        fin_crono = 2'b00; step();
        fin_crono = 2'b01;
        for (int k = 0; k < 24; k++) begin
            step();
            n_checks++;
            if (band_parp[0] !== exp_band(k) || alarm_active !== 2'b01 ||
                band_parp[1] !== 1'b0 || any_alarm !== 1'b1) begin
                n_fail++;
                $display("FAIL auto_stop k=%0d band=%b act=%b any=%b required band0=%b act=01 any=1",
                         k, band_parp, alarm_active, any_alarm, exp_band(k));
            end
        end
        step();
        n_checks++;
        if (band_parp !== 2'b00 || alarm_active !== 2'b00 || any_alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_stop_end band=%b act=%b any=%b required 00/00/0",
                     band_parp, alarm_active, any_alarm);
        end
        step();
        n_checks++;
        if (alarm_active !== 2'b00) begin
            n_fail++;
            $display("FAIL auto_stop_stays_idle act=%b required 00", alarm_active);
        end
    endtask

    task automatic test_ack();
        fin_crono = 2'b00; step();
        fin_crono = 2'b01;
        for (int k = 0; k < 6; k++) step();
        n_checks++;
        if (alarm_active !== 2'b01 || any_alarm !== 1'b1 || band_parp[0] !== exp_band(5)) begin
            n_fail++;
            $display("FAIL ack_pre act=%b any=%b band=%b required act=01 any=1 band0=%b",
                     alarm_active, any_alarm, band_parp, exp_band(5));
        end
        ack = 2'b01;
        step();
        ack = 2'b00;
        n_checks++;
        if (band_parp !== 2'b00 || alarm_active !== 2'b00 || any_alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_stop band=%b act=%b any=%b required 00/00/0",
                     band_parp, alarm_active, any_alarm);
        end
        ack = 2'b01;
        step();
        ack = 2'b00;
        n_checks++;
        if (band_parp !== 2'b00 || alarm_active !== 2'b00) begin
            n_fail++;
            $display("FAIL ack_in_idle band=%b act=%b required 00/00", band_parp, alarm_active);
        end
    endtask

    task automatic test_back_to_back();
        // Retrigger at ring cycle 12 with a plain edge.
        fin_crono = 2'b00; step();
        fin_crono = 2'b01;
        for (int k = 0; k < 11; k++) step();
        fin_crono = 2'b00; step();
        fin_crono = 2'b01;
        for (int k = 0; k < 24; k++) begin
            step();
            n_checks++;
            if (band_parp[0] !== exp_band(k) || alarm_active[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL retrig k=%0d band=%b act=%b required band0=%b act0=1",
                         k, band_parp, alarm_active, exp_band(k));
            end
        end
        step();
        n_checks++;
        if (band_parp !== 2'b00 || alarm_active !== 2'b00) begin
            n_fail++;
            $display("FAIL retrig_end band=%b act=%b required 00/00", band_parp, alarm_active);
        end
        // Retrigger with ack asserted on the same edge: the new event wins.
        fin_crono = 2'b00; step();
        fin_crono = 2'b01;
        for (int k = 0; k < 6; k++) step();
        fin_crono = 2'b00; step();
        fin_crono = 2'b01; ack = 2'b01;
        step();
        ack = 2'b00;
        for (int k = 0; k < 24; k++) begin
            if (k > 0) step();
            n_checks++;
            if (band_parp[0] !== exp_band(k) || alarm_active[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL retrig_ack k=%0d band=%b act=%b required band0=%b act0=1",
                         k, band_parp, alarm_active, exp_band(k));
            end
        end
        step();
        n_checks++;
        if (alarm_active !== 2'b00) begin
            n_fail++;
            $display("FAIL retrig_ack_end act=%b required 00", alarm_active);
        end
    endtask

    task automatic test_disable();
        fin_crono = 2'b00; step();
        fin_crono = 2'b10;
        step(); step(); step();
        n_checks++;
        if (alarm_active !== 2'b10 || band_parp !== 2'b10) begin
            n_fail++;
            $display("FAIL disable_pre act=%b band=%b required 10/10", alarm_active, band_parp);
        end
        enable = 1'b0; fin_crono = 2'b11;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (band_parp !== 2'b00 || alarm_active !== 2'b00 || any_alarm !== 1'b0) begin
                n_fail++;
                $display("FAIL disable_idle cyc=%0d band=%b act=%b any=%b required 00/00/0",
                         c, band_parp, alarm_active, any_alarm);
            end
        end
        enable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++;
            if (band_parp !== 2'b00 || alarm_active !== 2'b00) begin
                n_fail++;
                $display("FAIL disable_no_queue cyc=%0d band=%b act=%b required 00/00",
                         c, band_parp, alarm_active);
            end
        end
        fin_crono = 2'b00; step();
    endtask

    task automatic test_ring_forever();
        fin_crono = 2'b10;
        for (int k = 0; k < 120; k++) begin
            step();
            n_checks++;
            if (band_parp_nb0[1] !== exp_band(k) || alarm_active_nb0[1] !== 1'b1 ||
                any_alarm_nb0 !== 1'b1) begin
                n_fail++;
                $display("FAIL ring_forever k=%0d band=%b act=%b any=%b required band1=%b act1=1",
                         k, band_parp_nb0, alarm_active_nb0, any_alarm_nb0, exp_band(k));
            end
        end
        ack = 2'b10;
        step();
        ack = 2'b00;
        n_checks++;
        if (band_parp_nb0[1] !== 1'b0 || alarm_active_nb0[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL ring_forever_ack band=%b act=%b required band1=0 act1=0",
                     band_parp_nb0, alarm_active_nb0);
        end
        fin_crono = 2'b00; step();
    endtask

    initial begin
        test_reset();
        test_auto_stop();
        test_ack();
        test_back_to_back();
        test_disable();
        test_ring_forever();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
